// File: rtl/async_receiver_os.sv
// async_receiver_os: RS-232 8N1 receiver with 16x oversampling, framing-error,
// parity-error, idle-gap and end-of-packet reporting.
// Optional feature: define RX_PARITY_EN to receive a parity bit between the
// last data bit and the stop bit (even parity, or odd when ParityOdd = 1).
module async_receiver_os #(
  parameter int ClkFrequency          = 50000000,
  parameter int Baud                  = 9600,
  parameter int BaudGeneratorAccWidth = 16,
  parameter int ParityOdd             = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RxD,
  output logic [7:0] RxD_data,
  output logic       RxD_data_ready,
  output logic       RxD_frame_err,
  output logic       RxD_parity_err,
  output logic       RxD_busy,
  output logic       RxD_idle,
  output logic       RxD_endofpacket
);

  localparam int AccW = BaudGeneratorAccWidth;
  // Increment approximating Baud*16*2^AccW/ClkFrequency, rounded to nearest.
  localparam int IncCalc = ((Baud << (AccW - 3)) + (ClkFrequency >> 8)) / (ClkFrequency >> 7);
  localparam logic [AccW:0] Inc = (AccW + 1)'(IncCalc);
  localparam logic [7:0] GapFull = 8'd160;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} RxState;

  logic [AccW:0] acc;
  logic          tick;
  logic          rxSync1;
  logic          rxSync2;
  logic [1:0]    filterCnt;
  logic          filtered;
  RxState        state;
  logic [3:0]    cnt;
  logic [2:0]    bitIdx;
  logic [7:0]    shiftReg;
  logic [7:0]    gapCnt;
  logic          idlePrev;
  logic          gotByte;

  assign tick     = acc[AccW];
  assign filtered = filterCnt[1];
  assign RxD_busy = (state != IDLE);
  assign RxD_idle = (gapCnt == GapFull);

  // Free-running fractional accumulator; its carry bit is the 16x tick.
  always_ff @(posedge clk) begin
    if (rst) acc <= '0;
    else     acc <= {1'b0, acc[AccW-1:0]} + Inc;
  end

  // Two-flop synchronizer for the asynchronous pin, idling high.
  always_ff @(posedge clk) begin
    if (rst) begin
      rxSync1 <= 1'b1;
      rxSync2 <= 1'b1;
    end else begin
      rxSync1 <= RxD;
      rxSync2 <= rxSync1;
    end
  end

  // Saturating up/down counter per tick; its MSB is the debounced line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      filterCnt <= 2'b11;
    end else if (tick) begin
      if (rxSync2 && filterCnt != 2'b11)       filterCnt <= filterCnt + 2'd1;
      else if (!rxSync2 && filterCnt != 2'b00) filterCnt <= filterCnt - 2'd1;
    end
  end

`ifdef RX_PARITY_EN
  logic parityBit;

  // Frame state machine; bits are sampled when cnt wraps to 7 (mid-bit).
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      bitIdx         <= '0;
      shiftReg       <= '0;
      parityBit      <= 1'b0;
      RxD_data       <= '0;
      RxD_data_ready <= 1'b0;
      RxD_frame_err  <= 1'b0;
      RxD_parity_err <= 1'b0;
    end else begin
      RxD_data_ready <= 1'b0;
      RxD_frame_err  <= 1'b0;
      RxD_parity_err <= 1'b0;
      if (tick) begin
        cnt <= cnt + 4'd1;
        case (state)
          IDLE: if (!filtered) begin
            state <= START;
            cnt   <= '0;
          end
          START: if (cnt == 4'd7) begin
            state  <= filtered ? IDLE : DATA;
            bitIdx <= '0;
          end
          DATA: if (cnt == 4'd7) begin
            shiftReg <= {filtered, shiftReg[7:1]};
            bitIdx   <= bitIdx + 3'd1;
            if (bitIdx == 3'd7) state <= PARITY;
          end
          PARITY: if (cnt == 4'd7) begin
            parityBit <= filtered;
            state     <= STOP;
          end
          STOP: if (cnt == 4'd7) begin
            if (filtered) begin
              RxD_data       <= shiftReg;
              RxD_data_ready <= 1'b1;
              RxD_parity_err <= parityBit ^ (^shiftReg) ^ ParityOdd[0];
              state          <= IDLE;
            end else begin
              RxD_frame_err <= 1'b1;
              state         <= BREAK;
            end
          end
          BREAK: if (filtered) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
`else
  assign RxD_parity_err = 1'b0;

  // Frame state machine; bits are sampled when cnt wraps to 7 (mid-bit).
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      bitIdx         <= '0;
      shiftReg       <= '0;
      RxD_data       <= '0;
      RxD_data_ready <= 1'b0;
      RxD_frame_err  <= 1'b0;
    end else begin
      RxD_data_ready <= 1'b0;
      RxD_frame_err  <= 1'b0;
      if (tick) begin
        cnt <= cnt + 4'd1;
        case (state)
          IDLE: if (!filtered) begin
            state <= START;
            cnt   <= '0;
          end
          START: if (cnt == 4'd7) begin
            state  <= filtered ? IDLE : DATA;
            bitIdx <= '0;
          end
          DATA: if (cnt == 4'd7) begin
            shiftReg <= {filtered, shiftReg[7:1]};
            bitIdx   <= bitIdx + 3'd1;
            if (bitIdx == 3'd7) state <= STOP;
          end
          STOP: if (cnt == 4'd7) begin
            if (filtered) begin
              RxD_data       <= shiftReg;
              RxD_data_ready <= 1'b1;
              state          <= IDLE;
            end else begin
              RxD_frame_err <= 1'b1;
              state         <= BREAK;
            end
          end
          BREAK: if (filtered) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
`endif

  // Idle-gap counter and end-of-packet pulse after a burst of received bytes.
  always_ff @(posedge clk) begin
    if (rst) begin
      gapCnt          <= GapFull;
      idlePrev        <= 1'b1;
      gotByte         <= 1'b0;
      RxD_endofpacket <= 1'b0;
    end else begin
      RxD_endofpacket <= 1'b0;
      idlePrev        <= RxD_idle;
      if (state != IDLE || !filtered) gapCnt <= '0;
      else if (tick && gapCnt != GapFull) gapCnt <= gapCnt + 8'd1;
      if (RxD_data_ready) begin
        gotByte <= 1'b1;
      end else if (RxD_idle && !idlePrev && gotByte) begin
        RxD_endofpacket <= 1'b1;
        gotByte         <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_async_receiver_os.sv
// tb_async_receiver_os: directed bench for async_receiver_os at 64 clk/bit,
// one tick every 4 clk. Define RX_PARITY_EN to also exercise parity frames.
module tb_async_receiver_os;

  localparam int BitClk = 64;
`ifdef RX_PARITY_EN
  localparam bit HasParity = 1'b1;
`else
  localparam bit HasParity = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       RxD;
  logic [7:0] RxD_data;
  logic       RxD_data_ready;
  logic       RxD_frame_err;
  logic       RxD_parity_err;
  logic       RxD_busy;
  logic       RxD_idle;
  logic       RxD_endofpacket;

  int checks = 0;
  int errors = 0;
  int cycle = 0;

  int         readyCount = 0;
  int         frameErrCount = 0;
  int         parityErrCount = 0;
  int         eopCount = 0;
  int         eopCycle = 0;
  int         widthErr = 0;
  bit         sawBusy = 1'b0;
  logic [7:0] dataLog[16];
  int         readyCycleLog[16];
  logic       parityLog[16];
  logic       prevReady = 1'b0;
  logic       prevFrame = 1'b0;
  logic       prevParity = 1'b0;
  logic       prevEop = 1'b0;
  int         stopMid = 0;

  async_receiver_os #(
    .ClkFrequency(614400),
    .Baud(9600),
    .BaudGeneratorAccWidth(16),
    .ParityOdd(0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .RxD(RxD),
    .RxD_data(RxD_data),
    .RxD_data_ready(RxD_data_ready),
    .RxD_frame_err(RxD_frame_err),
    .RxD_parity_err(RxD_parity_err),
    .RxD_busy(RxD_busy),
    .RxD_idle(RxD_idle),
    .RxD_endofpacket(RxD_endofpacket)
  );

  // 10-unit clock period
  always #5 clk = ~clk;

  // Cycle counter used to timestamp strobes
  always @(posedge clk) cycle <= cycle + 1;

  // Strobe monitor sampled on the falling edge
  always @(negedge clk) begin
    if (RxD_data_ready) begin
      if (readyCount < 16) begin
        dataLog[readyCount]       = RxD_data;
        readyCycleLog[readyCount] = cycle;
        parityLog[readyCount]     = RxD_parity_err;
      end
      readyCount++;
    end
    if (RxD_frame_err) frameErrCount++;
    if (RxD_parity_err) parityErrCount++;
    if (RxD_endofpacket) begin
      eopCount++;
      eopCycle = cycle;
    end
    if (RxD_busy) sawBusy = 1'b1;
    if ((RxD_data_ready && prevReady) || (RxD_frame_err && prevFrame) ||
        (RxD_parity_err && prevParity) || (RxD_endofpacket && prevEop)) widthErr++;
    prevReady  = RxD_data_ready;
    prevFrame  = RxD_frame_err;
    prevParity = RxD_parity_err;
    prevEop    = RxD_endofpacket;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkRange(input string tag, input int observed, input int lo, input int hi);
    checks++;
    assert ((observed >= lo && observed <= hi) === 1'b1) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d..%0d", tag, observed, lo, hi);
    end
  endtask

  task automatic sendBit(input logic b);
    RxD = b;
    repeat (BitClk) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic parityBit, input logic stopBit);
    sendBit(1'b0);
    for (int i = 0; i < 8; i++) sendBit(data[i]);
    if (HasParity) sendBit(parityBit);
    stopMid = cycle + BitClk / 2;
    sendBit(stopBit);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_data"}, 32'(RxD_data), 32'h0);
    checkOutput({tag, "_ready"}, 32'(RxD_data_ready), 32'h0);
    checkOutput({tag, "_frame"}, 32'(RxD_frame_err), 32'h0);
    checkOutput({tag, "_parity"}, 32'(RxD_parity_err), 32'h0);
    checkOutput({tag, "_busy"}, 32'(RxD_busy), 32'h0);
    checkOutput({tag, "_idle"}, 32'(RxD_idle), 32'h1);
    checkOutput({tag, "_eop"}, 32'(RxD_endofpacket), 32'h0);
  endtask

  initial begin
    int rBase;
    int fBase;
    int eBase;
    int riseCycle;
    bit found;

    rst = 1'b1;
    RxD = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkResetOutputs("reset");
    repeat (20) @(negedge clk);

    // Scenario 1: back-to-back 0x55 and 0xA3
    rBase = readyCount;
    fBase = frameErrCount;
    applyStimulus(8'h55, 1'b0, 1'b1);
    checkOutput("s1_count0", 32'(readyCount - rBase), 32'd1);
    checkOutput("s1_data0", 32'(dataLog[rBase]), 32'h55);
    checkRange("s1_timing0", readyCycleLog[rBase] - stopMid, -36, 36);
    applyStimulus(8'hA3, 1'b0, 1'b1);
    checkOutput("s1_count1", 32'(readyCount - rBase), 32'd2);
    checkOutput("s1_data1", 32'(dataLog[rBase + 1]), 32'hA3);
    checkRange("s1_timing1", readyCycleLog[rBase + 1] - stopMid, -36, 36);
    checkOutput("s1_hold", 32'(RxD_data), 32'hA3);
    checkOutput("s1_noframe", 32'(frameErrCount - fBase), 32'd0);

    // Scenario 2: 8-clk glitch is rejected
    repeat (BitClk) @(negedge clk);
    rBase   = readyCount;
    fBase   = frameErrCount;
    sawBusy = 1'b0;
    RxD = 1'b0;
    repeat (8) @(negedge clk);
    RxD = 1'b1;
    repeat (40) @(negedge clk);
    checkOutput("s2_busy_low", 32'(RxD_busy), 32'h0);
    checkOutput("s2_reached_start", 32'(sawBusy), 32'h1);
    checkOutput("s2_noready", 32'(readyCount - rBase), 32'd0);
    checkOutput("s2_noframe", 32'(frameErrCount - fBase), 32'd0);

    // Scenario 3: framing error on 0x3C, 30-bit break, then 0x81
    repeat (BitClk) @(negedge clk);
    rBase = readyCount;
    fBase = frameErrCount;
    applyStimulus(8'h3C, 1'b0, 1'b0);
    repeat (30 * BitClk) @(negedge clk);
    checkOutput("s3_frame_once", 32'(frameErrCount - fBase), 32'd1);
    checkOutput("s3_noready", 32'(readyCount - rBase), 32'd0);
    checkOutput("s3_data_kept", 32'(RxD_data), 32'hA3);
    checkOutput("s3_busy_break", 32'(RxD_busy), 32'h1);
    RxD = 1'b1;
    repeat (2 * BitClk) @(negedge clk);
    checkOutput("s3_released", 32'(RxD_busy), 32'h0);
    applyStimulus(8'h81, 1'b0, 1'b1);
    checkOutput("s3_ready_after", 32'(readyCount - rBase), 32'd1);
    checkOutput("s3_data_after", 32'(RxD_data), 32'h81);
    checkOutput("s3_frame_total", 32'(frameErrCount - fBase), 32'd1);

    // Scenario 4: idle detection after 0x12
    repeat (800) @(negedge clk);
    eBase = eopCount;
    rBase = readyCount;
    applyStimulus(8'h12, 1'b0, 1'b1);
    checkOutput("s4_data", 32'(RxD_data), 32'h12);
    found     = 1'b0;
    riseCycle = 0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if (RxD_idle) begin
        found     = 1'b1;
        riseCycle = cycle;
        break;
      end
    end
    checkOutput("s4_idle_found", 32'(found), 32'h1);
    checkRange("s4_idle_delay", riseCycle - readyCycleLog[rBase], 636, 644);
    repeat (4) @(negedge clk);
    checkOutput("s4_eop_once", 32'(eopCount - eBase), 32'd1);
    checkRange("s4_eop_at_rise", eopCycle - riseCycle, 0, 2);
    repeat (1000) @(negedge clk);
    checkOutput("s4_no_second_eop", 32'(eopCount - eBase), 32'd1);
    checkOutput("s4_still_idle", 32'(RxD_idle), 32'h1);

    // Scenario 5: reset during data bit 4 of 0xFF, then 0x0F
    rBase = readyCount;
    sendBit(1'b0);
    for (int i = 0; i < 4; i++) sendBit(1'b1);
    repeat (BitClk / 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkResetOutputs("s5_reset");
    repeat (5 * BitClk) @(negedge clk);
    checkOutput("s5_no_aborted", 32'(readyCount - rBase), 32'd0);
    applyStimulus(8'h0F, 1'b0, 1'b1);
    checkOutput("s5_ready_after", 32'(readyCount - rBase), 32'd1);
    checkOutput("s5_data_after", 32'(RxD_data), 32'h0F);

`ifdef RX_PARITY_EN
    // Scenario 6: even parity on 0x07 (three ones, parity bit should be 1)
    repeat (BitClk) @(negedge clk);
    rBase = readyCount;
    applyStimulus(8'h07, 1'b1, 1'b1);
    checkOutput("s6_ready0", 32'(readyCount - rBase), 32'd1);
    checkOutput("s6_data0", 32'(dataLog[rBase]), 32'h07);
    checkOutput("s6_parity_ok", 32'(parityLog[rBase]), 32'h0);
    applyStimulus(8'h07, 1'b0, 1'b1);
    checkOutput("s6_ready1", 32'(readyCount - rBase), 32'd2);
    checkOutput("s6_data1", 32'(dataLog[rBase + 1]), 32'h07);
    checkOutput("s6_parity_bad", 32'(parityLog[rBase + 1]), 32'h1);
`else
    checkOutput("parity_never", 32'(parityErrCount), 32'd0);
`endif

    checkOutput("strobe_width", 32'(widthErr), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
